branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 4, meaning log2 of branch-history-table (BHT) entries (16 entries).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning width of the statistics counters.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port FETCH_PC, input, 10 bits: PC of the instruction in fetch.
REQ-006 SHALL have port FETCH_BRANCH_TYPE, input, 4 bits: predecoded branch type of the fetched instruction (0 none, 1 BRCC, 2 BRCS, 3 BREQ, 4 BRN, 5 BRNE, 6 CALL, 7 RET, 8 RETID, 9 RETIE, A-F unused).
REQ-007 SHALL have port BRANCH_PREDICTED, output, 1 bit: predicted-taken for the fetched instruction.
REQ-008 SHALL have port UPD_VALID, input, 1 bit: resolved branch present in execute this cycle.
REQ-009 SHALL have port UPD_PC, input, 10 bits: PC of the resolved instruction.
REQ-010 SHALL have port UPD_BRANCH_TYPE, input, 4 bits: branch type of the resolved instruction.
REQ-011 SHALL have port UPD_TAKEN, input, 1 bit: actual outcome (BRANCH_TAKEN from the resolve stage).
REQ-012 SHALL have port UPD_MISS, input, 1 bit: misprediction flag (branch_miss from the resolve stage).
REQ-013 SHALL have port BRANCH_COUNT, output, CNT_WIDTH bits: number of resolved conditional branches.
REQ-014 SHALL have port MISS_COUNT, output, CNT_WIDTH bits: number of resolved mispredictions (all types).

Function
REQ-015 SHALL hold 2**IDX_BITS two-bit saturating counters indexed by PC[IDX_BITS-1:0]; states 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-016 BRANCH_PREDICTED SHALL be combinational from FETCH_BRANCH_TYPE and the registered table, with zero-cycle latency.
REQ-017 For types 0 and A-F, BRANCH_PREDICTED SHALL be 0.
REQ-018 For types 4, 6, 7, 8, 9, BRANCH_PREDICTED SHALL be 1 regardless of table contents.
REQ-019 For types 1, 2, 3, 5, BRANCH_PREDICTED SHALL equal the MSB of the counter indexed by FETCH_PC.
REQ-020 On UPD_VALID=1 with a conditional UPD_BRANCH_TYPE (1, 2, 3, 5), the indexed counter SHALL increment if UPD_TAKEN=1 and decrement otherwise, taking effect the next cycle.
REQ-021 Counter updates SHALL saturate: 11 plus taken stays 11; 00 plus not-taken stays 00.
REQ-022 Unconditional, none, or unused types SHALL NOT modify the table.
REQ-023 UPD_VALID=0 SHALL leave the table and statistics unchanged, regardless of other UPD_* inputs.
REQ-024 With a same-cycle fetch and update to one index, the prediction SHALL use the pre-update value (no bypass).
REQ-025 Aliasing PCs, meaning PCs with equal low IDX_BITS, SHALL share one counter; no tags are kept.
REQ-026 BRANCH_COUNT SHALL increment by 1 on each UPD_VALID=1 with a conditional type.
REQ-027 MISS_COUNT SHALL increment by 1 on each UPD_VALID=1 with UPD_MISS=1, for any type.
REQ-028 BRANCH_COUNT and MISS_COUNT SHALL saturate at all-ones and not wrap.

Reset
REQ-029 While RST=1 at a rising CLK edge, all counters SHALL become 01 (weak-NT), and BRANCH_COUNT and MISS_COUNT SHALL become 0.
REQ-030 RST SHALL take priority over a simultaneous UPD_VALID; that update is discarded.
REQ-031 After reset, BRANCH_PREDICTED SHALL be 0 for conditional types and follow REQ-017/018 for the other types.

Structure
REQ-032 Branch-type encodings (4-bit enum, values 0-9) and a conditional-type predicate function SHALL live in the shared pipeline package, also used by the resolve stage.
REQ-033 The reset counter value (2'b01) SHALL be a package constant.
REQ-034 One sub-module, sat_counter2, SHALL implement the 2-bit saturate-up/down next-state logic; the BHT SHALL be a flat register array, not block RAM.

Verification
REQ-035 Reset test: RST high one cycle, then FETCH_BRANCH_TYPE=3 at any PC -> BRANCH_PREDICTED=0, BRANCH_COUNT=0, MISS_COUNT=0.
REQ-036 Training test: two updates PC=0x005, type 1, taken -> fetch PC=0x005 type 1 predicts 1; fetch PC=0x015 (alias) also predicts 1; fetch PC=0x006 predicts 0.
REQ-037 Saturation/hysteresis test: five taken updates at PC=0x00A, then one not-taken -> still predicts 1; second not-taken -> predicts 0.
REQ-038 Unconditional test: type 6 and type 9 predict 1 at a reset table; a type 4 update with UPD_TAKEN=0 leaves the counter at 01 and BRANCH_COUNT unchanged.
REQ-039 Collision and reset-priority test: same-cycle fetch and update at PC=0x003 from 01 with taken -> prediction 0 that cycle and 1 the next; update with RST=1 -> counter stays 01.
REQ-040 Statistics test: force MISS_COUNT to 0xFFFE, apply three UPD_MISS=1 updates -> MISS_COUNT reads 0xFFFF.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared pipeline definitions: branch-type encodings, type predicates and BHT constants.
// Used by the predictor and the resolve stage.
package branch_predictor_pkg;

    typedef enum logic [3:0] {
        BT_NONE  = 4'h0,
        BT_BRCC  = 4'h1,
        BT_BRCS  = 4'h2,
        BT_BREQ  = 4'h3,
        BT_BRN   = 4'h4,
        BT_BRNE  = 4'h5,
        BT_CALL  = 4'h6,
        BT_RET   = 4'h7,
        BT_RETID = 4'h8,
        BT_RETIE = 4'h9
    } branch_type_e;

    // Weak not-taken: one taken outcome is enough to flip the prediction.
    localparam logic [1:0] CNT_RESET = 2'b01;

    function automatic logic is_conditional(input logic [3:0] t);
        return (t == BT_BRCC) || (t == BT_BRCS) || (t == BT_BREQ) || (t == BT_BRNE);
    endfunction

    function automatic logic is_always_taken(input logic [3:0] t);
        return (t == BT_BRN) || (t == BT_CALL) || (t == BT_RET) ||
               (t == BT_RETID) || (t == BT_RETIE);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction, resolve-side update and statistics signals of the branch predictor.
interface branch_predictor_if #(
    parameter int CNT_WIDTH = 16
);
    logic [9:0]           FETCH_PC;
    logic [3:0]           FETCH_BRANCH_TYPE;
    logic                 BRANCH_PREDICTED;
    logic                 UPD_VALID;
    logic [9:0]           UPD_PC;
    logic [3:0]           UPD_BRANCH_TYPE;
    logic                 UPD_TAKEN;
    logic                 UPD_MISS;
    logic [CNT_WIDTH-1:0] BRANCH_COUNT;
    logic [CNT_WIDTH-1:0] MISS_COUNT;

    modport master (
        output FETCH_PC, FETCH_BRANCH_TYPE,
        output UPD_VALID, UPD_PC, UPD_BRANCH_TYPE, UPD_TAKEN, UPD_MISS,
        input  BRANCH_PREDICTED, BRANCH_COUNT, MISS_COUNT
    );

    modport slave (
        input  FETCH_PC, FETCH_BRANCH_TYPE,
        input  UPD_VALID, UPD_PC, UPD_BRANCH_TYPE, UPD_TAKEN, UPD_MISS,
        output BRANCH_PREDICTED, BRANCH_COUNT, MISS_COUNT
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic of a 2-bit saturating up/down counter (00 strong-NT .. 11 strong-T).
module sat_counter2 (
    input  logic [1:0] i_cnt,
    input  logic       i_taken,
    output logic [1:0] o_next
);
    always_comb begin
        o_next = i_cnt;
        if (i_taken) begin
            if (i_cnt != '1) o_next = i_cnt + 2'd1;
        end else begin
            if (i_cnt != '0) o_next = i_cnt - 2'd1;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: untagged table of 2-bit counters indexed by low PC bits,
// with saturating branch/mispredict statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic               CLK,
    input  logic               RST,
    branch_predictor_if.slave  bp
);
    localparam int ENTRIES = 2 ** IDX_BITS;

    logic [1:0]           r_bht [ENTRIES];
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_miss_cnt;

    logic [IDX_BITS-1:0]  w_fetch_idx;
    logic [IDX_BITS-1:0]  w_upd_idx;
    logic [1:0]           w_upd_next;
    logic                 w_upd_cond;
    logic                 w_unused;

    assign w_fetch_idx = bp.FETCH_PC[IDX_BITS-1:0];
    assign w_upd_idx   = bp.UPD_PC[IDX_BITS-1:0];
    assign w_upd_cond  = is_conditional(bp.UPD_BRANCH_TYPE);
    assign w_unused    = ^{bp.FETCH_PC[9:IDX_BITS], bp.UPD_PC[9:IDX_BITS]};

    sat_counter2 u_sat (
        .i_cnt   (r_bht[w_upd_idx]),
        .i_taken (bp.UPD_TAKEN),
        .o_next  (w_upd_next)
    );

    // Reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        bp.BRANCH_PREDICTED = 1'b0;
        if (is_always_taken(bp.FETCH_BRANCH_TYPE))
            bp.BRANCH_PREDICTED = 1'b1;
        else if (is_conditional(bp.FETCH_BRANCH_TYPE))
            bp.BRANCH_PREDICTED = r_bht[w_fetch_idx][1];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bht        <= '{default: CNT_RESET};
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else if (bp.UPD_VALID) begin
            if (w_upd_cond) begin
                r_bht[w_upd_idx] <= w_upd_next;
                if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
            end
            if (bp.UPD_MISS && (r_miss_cnt != '1))
                r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
        end
    end

    assign bp.BRANCH_COUNT = r_branch_cnt;
    assign bp.MISS_COUNT   = r_miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor against a behavioural table/statistics model.
module tb_branch_predictor;
    logic CLK = 1'b0;
    logic RST;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    int   m_bht [16];
    int   m_bc, m_mc;

    branch_predictor_if #(.CNT_WIDTH(16)) bp_if ();

    branch_predictor #(.IDX_BITS(4), .CNT_WIDTH(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bp  (bp_if)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int model_pred(input int pc, input int t);
        if (t == 4 || t == 6 || t == 7 || t == 8 || t == 9) return 1;
        if (t == 1 || t == 2 || t == 3 || t == 5) return (m_bht[pc % 16] >= 2) ? 1 : 0;
        return 0;
    endfunction

    // Behavioural model: plain counters clamped to their ranges.
    always @(posedge CLK) begin
        int t, i;
        t = int'(bp_if.UPD_BRANCH_TYPE);
        i = int'(bp_if.UPD_PC) % 16;
        if (RST) begin
            foreach (m_bht[k]) m_bht[k] = 1;
            m_bc = 0;
            m_mc = 0;
        end else if (bp_if.UPD_VALID) begin
            if (t == 1 || t == 2 || t == 3 || t == 5) begin
                if (bp_if.UPD_TAKEN) m_bht[i] = (m_bht[i] < 3) ? m_bht[i] + 1 : 3;
                else                 m_bht[i] = (m_bht[i] > 0) ? m_bht[i] - 1 : 0;
                if (m_bc < 65535) m_bc++;
            end
            if (bp_if.UPD_MISS && m_mc < 65535) m_mc++;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("pred_model", 32'(bp_if.BRANCH_PREDICTED),
                  32'(model_pred(int'(bp_if.FETCH_PC), int'(bp_if.FETCH_BRANCH_TYPE))));
            check("bcount_model", 32'(bp_if.BRANCH_COUNT), 32'(m_bc));
            check("mcount_model", 32'(bp_if.MISS_COUNT), 32'(m_mc));
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic upd(input logic [9:0] pc, input logic [3:0] t, input logic tk, input logic miss);
        bp_if.UPD_VALID       = 1'b1;
        bp_if.UPD_PC          = pc;
        bp_if.UPD_BRANCH_TYPE = t;
        bp_if.UPD_TAKEN       = tk;
        bp_if.UPD_MISS        = miss;
        step();
        bp_if.UPD_VALID = 1'b0;
    endtask

    task automatic fetch_chk(input string name, input logic [9:0] pc, input logic [3:0] t, input logic exp);
        bp_if.FETCH_PC          = pc;
        bp_if.FETCH_BRANCH_TYPE = t;
        #1;
        check(name, 32'(bp_if.BRANCH_PREDICTED), 32'(exp));
    endtask

    initial begin
        RST = 1'b1;
        bp_if.FETCH_PC = '0;
        bp_if.FETCH_BRANCH_TYPE = '0;
        bp_if.UPD_VALID = 1'b0;
        bp_if.UPD_PC = '0;
        bp_if.UPD_BRANCH_TYPE = '0;
        bp_if.UPD_TAKEN = 1'b0;
        bp_if.UPD_MISS = 1'b0;
        step();

        // Reset with a simultaneous update: the update must be discarded.
        upd(10'h003, 4'h1, 1'b1, 1'b1);
        RST = 1'b0;
        chk_en = 1'b1;
        fetch_chk("reset_pred_t3", 10'h123, 4'h3, 1'b0);
        fetch_chk("reset_prio_pc3", 10'h003, 4'h1, 1'b0);
        check("reset_bcount", 32'(bp_if.BRANCH_COUNT), 32'd0);
        check("reset_mcount", 32'(bp_if.MISS_COUNT), 32'd0);
        fetch_chk("type0_pred", 10'h005, 4'h0, 1'b0);
        fetch_chk("typeF_pred", 10'h005, 4'hF, 1'b0);

        // Unconditional types.
        fetch_chk("type6_pred", 10'h000, 4'h6, 1'b1);
        fetch_chk("type9_pred", 10'h000, 4'h9, 1'b1);
        upd(10'h002, 4'h4, 1'b0, 1'b0);
        fetch_chk("brn_upd_no_change", 10'h002, 4'h1, 1'b0);
        check("brn_upd_bcount", 32'(bp_if.BRANCH_COUNT), 32'd0);
        upd(10'h002, 4'h4, 1'b0, 1'b0);
        upd(10'h002, 4'h2, 1'b1, 1'b0);
        fetch_chk("brn_then_cond_taken", 10'h002, 4'h2, 1'b1);

        // Training and aliasing.
        upd(10'h005, 4'h1, 1'b1, 1'b1);
        upd(10'h005, 4'h1, 1'b1, 1'b0);
        fetch_chk("train_pc5", 10'h005, 4'h1, 1'b1);
        fetch_chk("train_alias_pc15", 10'h015, 4'h1, 1'b1);
        fetch_chk("train_pc6", 10'h006, 4'h1, 1'b0);
        check("train_bcount", 32'(bp_if.BRANCH_COUNT), 32'd3);
        check("train_mcount", 32'(bp_if.MISS_COUNT), 32'd1);

        // Idle update lines with UPD_VALID low change nothing.
        bp_if.UPD_PC = 10'h005;
        bp_if.UPD_BRANCH_TYPE = 4'h1;
        bp_if.UPD_TAKEN = 1'b0;
        bp_if.UPD_MISS = 1'b1;
        repeat (3) step();
        fetch_chk("idle_pc5", 10'h005, 4'h1, 1'b1);
        check("idle_mcount", 32'(bp_if.MISS_COUNT), 32'd1);

        // Saturation and hysteresis.
        repeat (5) upd(10'h00A, 4'h2, 1'b1, 1'b0);
        upd(10'h00A, 4'h2, 1'b0, 1'b1);
        fetch_chk("hyst_one_nt", 10'h00A, 4'h2, 1'b1);
        upd(10'h00A, 4'h5, 1'b0, 1'b1);
        fetch_chk("hyst_two_nt", 10'h00A, 4'h2, 1'b0);
        repeat (4) upd(10'h01A, 4'h3, 1'b0, 1'b0);
        upd(10'h00A, 4'h3, 1'b1, 1'b0);
        fetch_chk("floor_sat", 10'h00A, 4'h3, 1'b0);

        // Same-cycle fetch and update: no bypass.
        bp_if.FETCH_PC = 10'h003;
        bp_if.FETCH_BRANCH_TYPE = 4'h3;
        bp_if.UPD_VALID = 1'b1;
        bp_if.UPD_PC = 10'h003;
        bp_if.UPD_BRANCH_TYPE = 4'h3;
        bp_if.UPD_TAKEN = 1'b1;
        bp_if.UPD_MISS = 1'b0;
        #1;
        check("collide_same_cycle", 32'(bp_if.BRANCH_PREDICTED), 32'd0);
        step();
        bp_if.UPD_VALID = 1'b0;
        fetch_chk("collide_next_cycle", 10'h003, 4'h3, 1'b1);

        // Reset priority over an update on a trained entry.
        RST = 1'b1;
        upd(10'h003, 4'h3, 1'b1, 1'b1);
        RST = 1'b0;
        fetch_chk("rst_prio_pc3", 10'h003, 4'h3, 1'b0);
        upd(10'h003, 4'h3, 1'b1, 1'b0);
        fetch_chk("rst_left_weak_nt", 10'h003, 4'h3, 1'b1);

        // Statistics saturation.
        RST = 1'b1;
        step();
        RST = 1'b0;
        bp_if.UPD_PC = 10'h000;
        bp_if.UPD_BRANCH_TYPE = 4'h0;
        bp_if.UPD_TAKEN = 1'b0;
        bp_if.UPD_MISS = 1'b1;
        bp_if.UPD_VALID = 1'b1;
        repeat (65534) step();
        bp_if.UPD_VALID = 1'b0;
        #1;
        check("mcount_fffe", 32'(bp_if.MISS_COUNT), 32'h0000FFFE);
        check("mcount_bcount_zero", 32'(bp_if.BRANCH_COUNT), 32'd0);
        repeat (3) upd(10'h001, 4'h7, 1'b1, 1'b1);
        #1;
        check("mcount_sat", 32'(bp_if.MISS_COUNT), 32'h0000FFFF);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
